// File: rtl/i2s_tx_stream.sv
// rtl/i2s_tx_stream.sv - stereo I2S transmitter fed from an internal ring-buffer sample memory
// Optional loopback receiver is compiled in when I2S_TX_LOOPBACK_EN is defined.
module i2s_tx_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  conf_en,
  input  logic                  conf_swap,
  input  logic [5:0]            conf_res,
  input  logic [DIV_WIDTH-1:0]  conf_ratio,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] address_r,
  output logic                  evt_lsbf,
  output logic                  evt_hsbf,
  output logic                  i2s_sck,
  output logic                  i2s_ws,
  output logic                  i2s_sd,
  input  logic                  i2s_sd_i,
  output logic [DATA_WIDTH-1:0] sample_dat_o,
  output logic                  rx_valid
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] HALF_LAST = ADDR_WIDTH'(DEPTH / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [6:0]            DW7       = 7'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, PREFETCH, SHIFT, DRAIN} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  rd_issue;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  swap_q;
  logic                  pre_wait;
  logic                  pf_req;
  logic [DATA_WIDTH-1:0] sr;
  logic [6:0]            bit_cnt;
  logic [6:0]            res_q;
  logic [6:0]            res_c;
  logic [DIV_WIDTH-1:0]  ratio_q;
  logic [DIV_WIDTH-1:0]  div_cnt;
  logic                  pad_pending;
  logic                  done;
  logic                  running;
  logic                  tick;
  logic                  fall_tick;
  logic                  last_bit;

  // Read-first: a same-cycle write to the read address returns the old word.
  always_ff @(posedge wb_clk) begin
    if (wr_en) mem[wr_addr] <= data_in;
    if (rd_issue) ram_q <= mem[rd_addr];
  end

  assign res_c     = ({1'b0, conf_res} == 7'd0 || {1'b0, conf_res} > DW7) ? DW7 : {1'b0, conf_res};
  assign running   = (state == SHIFT) || (state == DRAIN);
  assign tick      = running && (div_cnt == ratio_q);
  assign fall_tick = tick && i2s_sck;
  assign last_bit  = !pad_pending && !done && (bit_cnt == res_q - 7'd1);
  assign rd_issue  = (state == PREFETCH && !pre_wait) || pf_req;
  // Even pointer = left word of the frame; swap is latched there for the right word.
  assign rd_addr   = {rd_ptr[ADDR_WIDTH-1:1], rd_ptr[0] ^ (rd_ptr[0] ? swap_q : conf_swap)};
  assign address_r = rd_ptr;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (conf_en) state_nxt = PREFETCH;
      PREFETCH: if (pre_wait) state_nxt = SHIFT;
      SHIFT:    if (!conf_en) state_nxt = DRAIN;
      DRAIN:    if (fall_tick && done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rd_ptr      <= '0;
      swap_q      <= 1'b0;
      pre_wait    <= 1'b0;
      pf_req      <= 1'b0;
      sr          <= '0;
      bit_cnt     <= '0;
      res_q       <= DW7;
      ratio_q     <= '0;
      div_cnt     <= '0;
      pad_pending <= 1'b0;
      done        <= 1'b0;
      i2s_sck     <= 1'b0;
      i2s_ws      <= 1'b0;
      i2s_sd      <= 1'b0;
      evt_lsbf    <= 1'b0;
      evt_hsbf    <= 1'b0;
    end else begin
      evt_lsbf <= 1'b0;
      evt_hsbf <= 1'b0;
      pf_req   <= 1'b0;
      if (rd_issue) begin
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        evt_lsbf <= (rd_ptr == HALF_LAST);
        evt_hsbf <= (rd_ptr == LAST);
        if (!rd_ptr[0]) swap_q <= conf_swap;
      end
      case (state)
        IDLE: begin
          rd_ptr   <= '0;
          div_cnt  <= '0;
          i2s_sck  <= 1'b0;
          i2s_ws   <= 1'b0;
          i2s_sd   <= 1'b0;
          pre_wait <= 1'b0;
          done     <= 1'b0;
        end
        PREFETCH: begin
          pre_wait <= 1'b1;
          if (pre_wait) begin
            pre_wait    <= 1'b0;
            sr          <= ram_q;
            bit_cnt     <= '0;
            res_q       <= res_c;
            ratio_q     <= conf_ratio;
            pad_pending <= 1'b1;
            pf_req      <= 1'b1;
          end
        end
        default: begin
          if (tick) begin
            div_cnt <= '0;
            i2s_sck <= ~i2s_sck;
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
          if (fall_tick) begin
            if (done || pad_pending) begin
              i2s_sd      <= 1'b0;
              i2s_ws      <= 1'b0;
              done        <= 1'b0;
              pad_pending <= 1'b0;
            end else begin
              i2s_sd  <= sr[DATA_WIDTH-1];
              sr      <= {sr[DATA_WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt + 7'd1;
              if (last_bit) begin
                i2s_ws  <= ~i2s_ws;
                bit_cnt <= '0;
                if (state == DRAIN && i2s_ws) begin
                  done <= 1'b1;
                end else begin
                  // Slot boundary: next word and new slot configuration take over.
                  sr      <= ram_q;
                  res_q   <= res_c;
                  ratio_q <= conf_ratio;
                  pf_req  <= (state == SHIFT) && conf_en;
                end
              end
            end
          end
        end
      endcase
    end
  end

`ifdef I2S_TX_LOOPBACK_EN
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  rx_armed;
  logic                  rx_last;
  logic [6:0]            rx_res;
  logic                  rise_tick;

  assign rise_tick = tick && !i2s_sck;

  // Bits leave on the fall tick and are captured on the following rise.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rx_sr        <= '0;
      rx_armed     <= 1'b0;
      rx_last      <= 1'b0;
      rx_res       <= DW7;
      sample_dat_o <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!running) begin
        rx_armed <= 1'b0;
        rx_last  <= 1'b0;
      end
      if (fall_tick) begin
        rx_armed <= !pad_pending && !done;
        rx_last  <= last_bit;
        if (last_bit) rx_res <= res_q;
      end
      if (rise_tick && rx_armed) begin
        rx_sr <= {rx_sr[DATA_WIDTH-2:0], i2s_sd_i};
        if (rx_last) begin
          sample_dat_o <= {rx_sr[DATA_WIDTH-2:0], i2s_sd_i} << (DW7 - rx_res);
          rx_valid     <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_sd_i;
  assign unused_sd_i  = i2s_sd_i;
  assign sample_dat_o = '0;
  assign rx_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_tx_stream.sv
// tb/tb_i2s_tx_stream.sv - scoreboard bench for i2s_tx_stream (ADDR_WIDTH=4)
module tb_i2s_tx_stream;
  logic        clk = 1'b0;
  logic        wb_rst;
  logic        conf_en;
  logic        conf_swap;
  logic [5:0]  conf_res;
  logic [15:0] conf_ratio;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] data_in;
  logic [3:0]  address_r;
  logic        evt_lsbf, evt_hsbf;
  logic        i2s_sck, i2s_ws, i2s_sd;
  logic        sd_loop;
  logic [15:0] sample_dat_o;
  logic        rx_valid;

  assign sd_loop = i2s_sd;

  i2s_tx_stream #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DIV_WIDTH(16)) dut (
    .wb_clk(clk), .wb_rst(wb_rst), .conf_en(conf_en), .conf_swap(conf_swap),
    .conf_res(conf_res), .conf_ratio(conf_ratio), .wr_en(wr_en), .wr_addr(wr_addr),
    .data_in(data_in), .address_r(address_r), .evt_lsbf(evt_lsbf), .evt_hsbf(evt_hsbf),
    .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd), .i2s_sd_i(sd_loop),
    .sample_dat_o(sample_dat_o), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  res;
    logic        swap;
    logic [15:0] ratio;
    logic [15:0] left;
    logic [15:0] right;
    int          r;
  } vec_t;

  vec_t        tv[6];
  logic [1:0]  exp_q[$];
  logic [15:0] rx_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          last_fall = -1;
  int          ratio_cur = 1;
  logic        mon_en = 1'b0;
  logic        prev_sck = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en && prev_sck && !i2s_sck) begin
      if (exp_q.size() == 0) begin
        check("extra_sck_fall", 1, 0);
      end else begin
        check("ws_sd_bit", {i2s_ws, i2s_sd}, exp_q.pop_front());
      end
      if (last_fall >= 0) check("sck_period", cyc - last_fall, 2 * (ratio_cur + 1));
      last_fall = cyc;
`ifndef I2S_TX_LOOPBACK_EN
      check("rx_idle", {rx_valid, sample_dat_o}, 0);
`endif
    end
`ifdef I2S_TX_LOOPBACK_EN
    if (mon_en && rx_valid) begin
      if (rx_q.size() == 0) check("extra_rx_valid", 1, 0);
      else check("rx_sample", sample_dat_o, rx_q.pop_front());
    end
`endif
    prev_sck = i2s_sck;
  end

  task automatic push_slot(logic [15:0] v, int r, logic ws);
    logic [15:0] ones = 16'hFFFF;
    for (int k = 0; k < r; k++) exp_q.push_back({(k == r - 1) ? ~ws : ws, v[15-k]});
    rx_q.push_back(v & ~(ones >> r));
  endtask

  task automatic wait_q(int target, string what);
    int n = 0;
    while (exp_q.size() > target && n < 4000) begin
      step();
      n++;
    end
    check(what, exp_q.size() > target, 0);
  endtask

  task automatic run_vec(int i);
    int total;
    conf_res   = tv[i].res;
    conf_swap  = tv[i].swap;
    conf_ratio = tv[i].ratio;
    ratio_cur  = int'(tv[i].ratio);
    exp_q.delete();
    rx_q.delete();
    exp_q.push_back(2'b00);
    push_slot(tv[i].left, tv[i].r, 1'b0);
    push_slot(tv[i].right, tv[i].r, 1'b1);
    exp_q.push_back(2'b00);
    total     = exp_q.size();
    last_fall = -1;
    mon_en    = 1'b1;
    conf_en   = 1'b1;
    wait_q(total - ((tv[i].r > 1) ? 2 : 1), "enable_timeout");
    conf_en = 1'b0;
    wait_q(0, "drain_timeout");
    repeat (4) step();
    check("stopped_outputs", {i2s_sck, i2s_ws, i2s_sd, address_r}, 0);
`ifdef I2S_TX_LOOPBACK_EN
    check("rx_all_seen", rx_q.size(), 0);
`endif
    mon_en = 1'b0;
  endtask

  initial begin
    int n;
    int lsb_cnt;
    int hsb_cnt;
    tv[0] = '{6'd16, 1'b0, 16'd1, 16'hA5F0, 16'h0F0F, 16};
    tv[1] = '{6'd8,  1'b0, 16'd1, 16'hA5F0, 16'h0F0F, 8};
    tv[2] = '{6'd4,  1'b1, 16'd0, 16'h0F0F, 16'hA5F0, 4};
    tv[3] = '{6'd0,  1'b0, 16'd2, 16'hA5F0, 16'h0F0F, 16};
    tv[4] = '{6'd40, 1'b1, 16'd0, 16'h0F0F, 16'hA5F0, 16};
    tv[5] = '{6'd1,  1'b0, 16'd3, 16'hA5F0, 16'h0F0F, 1};

    wb_rst = 1'b1; conf_en = 1'b0; conf_swap = 1'b0; conf_res = 6'd16;
    conf_ratio = 16'd1; wr_en = 1'b0; wr_addr = '0; data_in = '0;
    repeat (3) step();
    check("reset_outputs", {address_r, evt_lsbf, evt_hsbf, i2s_sck, i2s_ws, i2s_sd, rx_valid, sample_dat_o}, 0);
    wb_rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      data_in = (a == 0) ? 16'hA5F0 : (a == 1) ? 16'h0F0F : 16'(a * 16'h1357);
      step();
    end
    wr_en = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Half-buffer events over two full passes of the 16-word ring.
    conf_res = 6'd1; conf_ratio = 16'd0; conf_swap = 1'b0; conf_en = 1'b1;
    lsb_cnt = 0; hsb_cnt = 0; n = 0;
    while (hsb_cnt < 2 && n < 2000) begin
      step();
      n++;
      if (evt_lsbf) begin
        lsb_cnt++;
        check("lsbf_addr", address_r, 8);
      end
      if (evt_hsbf) begin
        hsb_cnt++;
        check("hsbf_addr", address_r, 0);
        check("one_lsbf_per_pass", lsb_cnt, hsb_cnt);
      end
    end
    check("event_timeout", hsb_cnt, 2);
    conf_en = 1'b0;
    repeat (40) step();
    check("events_stop", {i2s_sck, i2s_ws, i2s_sd, address_r}, 0);

    // Reset mid-slot, then restart from address 0 with memory intact.
    conf_res = 6'd16; conf_ratio = 16'd1; conf_en = 1'b1;
    repeat (30) step();
    wb_rst = 1'b1;
    conf_en = 1'b0;
    step();
    check("midslot_reset", {address_r, evt_lsbf, evt_hsbf, i2s_sck, i2s_ws, i2s_sd, rx_valid, sample_dat_o}, 0);
    wb_rst = 1'b0;
    step();
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
